// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared direction codes, fetch states and window helpers for the Sobel front end
package sobel_pkg;

    localparam logic [1:0] DIR_FULL  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FULL = 2'd1,
        ST_PART = 2'd2,
        ST_DONE = 2'd3
    } fetch_state_t;

    localparam int PIX_W   = 8;
    localparam int WIN_DIM = 3;
    localparam int WIN_W   = PIX_W * WIN_DIM * WIN_DIM;

    localparam logic [1:0] WIN_ROW_TOP   = 2'd0;
    localparam logic [1:0] WIN_ROW_MID   = 2'd1;
    localparam logic [1:0] WIN_ROW_BOT   = 2'd2;
    localparam logic [1:0] WIN_COL_LEFT  = 2'd0;
    localparam logic [1:0] WIN_COL_MID   = 2'd1;
    localparam logic [1:0] WIN_COL_RIGHT = 2'd2;

    localparam logic [3:0] IDX_FULL_LAST = 4'd8;
    localparam logic [3:0] IDX_PART_LAST = 4'd2;

    // Move the retained pixels so the newly exposed row/column is the one about to be read
    function automatic logic [WIN_W-1:0] shift_window(input logic [WIN_W-1:0] win,
                                                      input logic [1:0] dir);
        logic [WIN_W-1:0] res;
        res = win;
        for (int r = 0; r < WIN_DIM; r++) begin
            case (dir)
                DIR_RIGHT: begin
                    res[(r*3+0)*PIX_W +: PIX_W] = win[(r*3+1)*PIX_W +: PIX_W];
                    res[(r*3+1)*PIX_W +: PIX_W] = win[(r*3+2)*PIX_W +: PIX_W];
                end
                DIR_LEFT: begin
                    res[(r*3+2)*PIX_W +: PIX_W] = win[(r*3+1)*PIX_W +: PIX_W];
                    res[(r*3+1)*PIX_W +: PIX_W] = win[(r*3+0)*PIX_W +: PIX_W];
                end
                DIR_DOWN: begin
                    res[(0*3+r)*PIX_W +: PIX_W] = win[(1*3+r)*PIX_W +: PIX_W];
                    res[(1*3+r)*PIX_W +: PIX_W] = win[(2*3+r)*PIX_W +: PIX_W];
                end
                default: ;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/window_addr_gen.sv
// rtl/window_addr_gen.sv - maps (centre, row length, direction, read index) to frame address and window slot
module window_addr_gen
    import sobel_pkg::*;
(
    input  logic [7:0] i_center,
    input  logic [7:0] i_length,
    input  logic [1:0] i_dir,
    input  logic [3:0] i_idx,
    output logic [7:0] o_addr,
    output logic [3:0] o_slot
);

    logic [1:0] w_row;
    logic [1:0] w_col;
    logic [7:0] w_row_off;
    logic [7:0] w_col_off;

    // Pick the window cell for this read: full loads walk row-major, moves walk the exposed edge
    always_comb begin
        w_row = WIN_ROW_MID;
        w_col = WIN_COL_MID;
        case (i_dir)
            DIR_RIGHT: begin
                w_row = i_idx[1:0];
                w_col = WIN_COL_RIGHT;
            end
            DIR_LEFT: begin
                w_row = i_idx[1:0];
                w_col = WIN_COL_LEFT;
            end
            DIR_DOWN: begin
                w_row = WIN_ROW_BOT;
                w_col = i_idx[1:0];
            end
            default: begin
                if (i_idx < 4'd3) begin
                    w_row = WIN_ROW_TOP;
                    w_col = i_idx[1:0];
                end else if (i_idx < 4'd6) begin
                    w_row = WIN_ROW_MID;
                    w_col = 2'(i_idx - 4'd3);
                end else begin
                    w_row = WIN_ROW_BOT;
                    w_col = 2'(i_idx - 4'd6);
                end
            end
        endcase
    end

    // Offsets wrap modulo 256 so the window simply folds around the frame memory
    assign w_row_off = (w_row == WIN_ROW_TOP) ? (8'd0 - i_length) :
                       (w_row == WIN_ROW_BOT) ? i_length : 8'd0;
    assign w_col_off = (w_col == WIN_COL_LEFT)  ? 8'hFF :
                       (w_col == WIN_COL_RIGHT) ? 8'h01 : 8'h00;

    assign o_addr = i_center + w_row_off + w_col_off;
    assign o_slot = ({2'b00, w_row} * 4'd3) + {2'b00, w_col};

endmodule

// File: rtl/window_fetch.sv
// rtl/window_fetch.sv - 3x3 Sobel window fetcher; optional read timeout under FETCH_TIMEOUT_EN
module window_fetch
    import sobel_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        load_initial,
    input  logic        fetch_req,
    input  logic [1:0]  direction,
    input  logic [7:0]  center_addr,
    input  logic [11:0] length,
    output logic [7:0]  mem_addr,
    output logic        mem_read,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [71:0] window,
    output logic        window_valid,
    output logic        busy,
    output logic        fetch_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    fetch_state_t r_state;
    logic [1:0]   r_dir;
    logic [3:0]   r_idx;
    logic [3:0]   r_slot;
    logic [7:0]   r_mem_addr;
    logic         r_mem_read;
    logic [71:0]  r_window;
    logic         r_valid;

    logic         w_busy;
    logic         w_accept;
    logic         w_last;
    logic         w_take;
    logic [7:0]   w_byte;
    logic [1:0]   w_new_dir;
    logic [1:0]   w_gen_dir;
    logic [3:0]   w_gen_idx;
    logic [3:0]   w_gen_slot;
    logic [7:0]   w_gen_addr;
    logic         w_unused_len_hi;

    assign w_unused_len_hi = ^length[11:8];

    assign w_busy    = (r_state == ST_FULL) || (r_state == ST_PART);
    // load_initial always wins; fetch_req only lands when nothing is in flight
    assign w_accept  = load_initial || (fetch_req && !w_busy);
    assign w_new_dir = load_initial ? DIR_FULL : direction;
    assign w_gen_dir = w_accept ? w_new_dir : r_dir;
    assign w_gen_idx = w_accept ? 4'd0 : (r_idx + 4'd1);
    assign w_last    = (r_idx == ((r_dir == DIR_FULL) ? IDX_FULL_LAST : IDX_PART_LAST));

    window_addr_gen u_addr_gen (
        .i_center (center_addr),
        .i_length (length[7:0]),
        .i_dir    (w_gen_dir),
        .i_idx    (w_gen_idx),
        .o_addr   (w_gen_addr),
        .o_slot   (w_gen_slot)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_err;
    logic             w_tmo_hit;

    assign w_tmo_hit = r_mem_read && !mem_ack && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_take    = r_mem_read && (mem_ack || w_tmo_hit);
    assign w_byte    = mem_ack ? mem_rdata : 8'h00;
    assign fetch_err = r_err;

    // Per-read wait counter, restarted whenever a new address goes out
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_tmo_cnt <= '0;
        end else if (w_accept || !r_mem_read || mem_ack || w_tmo_hit) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Sticky error: any abandoned read is remembered until reset
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_err <= 1'b0;
        end else if (w_tmo_hit && !w_accept) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_take    = r_mem_read && mem_ack;
    assign w_byte    = mem_rdata;
    assign fetch_err = 1'b0;
`endif

    // Fetch sequencer: accept, shift, issue one read at a time, land bytes into their slots
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state    <= ST_IDLE;
            r_dir      <= DIR_FULL;
            r_idx      <= 4'd0;
            r_slot     <= 4'd0;
            r_mem_addr <= 8'd0;
            r_mem_read <= 1'b0;
            r_window   <= '0;
            r_valid    <= 1'b0;
        end else if (w_accept) begin
            r_state    <= (w_new_dir == DIR_FULL) ? ST_FULL : ST_PART;
            r_dir      <= w_new_dir;
            r_idx      <= 4'd0;
            r_slot     <= w_gen_slot;
            r_mem_addr <= w_gen_addr;
            r_mem_read <= 1'b1;
            r_valid    <= 1'b0;
            r_window   <= shift_window(r_window, w_new_dir);
        end else if (w_busy && w_take) begin
            r_window[{r_slot, 3'b000} +: PIX_W] <= w_byte;
            if (w_last) begin
                r_state    <= ST_DONE;
                r_mem_read <= 1'b0;
                r_valid    <= 1'b1;
            end else begin
                r_idx      <= r_idx + 4'd1;
                r_slot     <= w_gen_slot;
                r_mem_addr <= w_gen_addr;
            end
        end
    end

    assign mem_addr     = r_mem_addr;
    assign mem_read     = r_mem_read;
    assign window       = r_window;
    assign window_valid = r_valid;
    assign busy         = w_busy;

endmodule

// File: tb/tb_window_fetch.sv
// tb/tb_window_fetch.sv - randomized self-checking bench for window_fetch against a window-level model
module tb_window_fetch;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        load_initial;
    logic        fetch_req;
    logic [1:0]  direction;
    logic [7:0]  center_addr;
    logic [11:0] length;
    logic [7:0]  mem_addr;
    logic        mem_read;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [71:0] window;
    logic        window_valid;
    logic        busy;
    logic        fetch_err;

    always #5 clk = ~clk;

    window_fetch #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .load_initial (load_initial),
        .fetch_req    (fetch_req),
        .direction    (direction),
        .center_addr  (center_addr),
        .length       (length),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .window       (window),
        .window_valid (window_valid),
        .busy         (busy),
        .fetch_err    (fetch_err)
    );

    logic [7:0] mem [256];
    int         wait_cfg = 0;
    int         wait_cnt = 0;
    bit         noack_en = 1'b0;
    logic [7:0] noack_addr = 8'h00;
    logic [7:0] rd_log [$];
    int         stab_err = 0;
    bit         hold = 1'b0;
    logic [7:0] hold_addr = 8'h00;

    int n_pass = 0;
    int n_checks = 0;

    logic [7:0] m [3][3];
    logic [7:0] exp_addr [$];
    logic [7:0] exp_log [$];
    int         exp_lat;
    bit         exp_err = 1'b0;
    logic [7:0] full_exp [9];

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_read && (wait_cnt >= wait_cfg) && !(noack_en && mem_addr == noack_addr);

    always @(posedge clk) begin
        if (!n_reset || !mem_read || mem_ack || load_initial) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    always @(negedge clk) begin
        if (hold && mem_read && mem_addr != hold_addr) stab_err <= stab_err + 1;
        if (n_reset && mem_read && mem_ack && !load_initial) rd_log.push_back(mem_addr);
        hold      <= n_reset && mem_read && !mem_ack && !load_initial && !(noack_en && mem_addr == noack_addr);
        hold_addr <= mem_addr;
    end

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] wrap_addr(input logic [7:0] c, input logic [7:0] l, input int dr, input int dc);
        int s;
        s = int'(c) + dr * int'(l) + dc;
        return 8'(s & 255);
    endfunction

    task automatic model_read(input logic [7:0] a, input int wt, output logic [7:0] d);
        exp_addr.push_back(a);
        if (noack_en && a == noack_addr) begin
            d = 8'h00;
            exp_lat += TMO;
        end else begin
            d = mem[a];
            exp_log.push_back(a);
            exp_lat += wt + 1;
        end
    endtask

    task automatic model_op(input logic [1:0] eff, input logic [7:0] c, input logic [7:0] l, input int wt);
        exp_addr.delete();
        exp_log.delete();
        exp_lat = 0;
        case (eff)
            2'b00: for (int r = 0; r < 3; r++) for (int k = 0; k < 3; k++)
                       model_read(wrap_addr(c, l, r - 1, k - 1), wt, m[r][k]);
            2'b01: begin
                for (int r = 0; r < 3; r++) begin m[r][0] = m[r][1]; m[r][1] = m[r][2]; end
                for (int r = 0; r < 3; r++) model_read(wrap_addr(c, l, r - 1, 1), wt, m[r][2]);
            end
            2'b10: begin
                for (int r = 0; r < 3; r++) begin m[r][2] = m[r][1]; m[r][1] = m[r][0]; end
                for (int r = 0; r < 3; r++) model_read(wrap_addr(c, l, r - 1, -1), wt, m[r][0]);
            end
            default: begin
                for (int k = 0; k < 3; k++) begin m[0][k] = m[1][k]; m[1][k] = m[2][k]; end
                for (int k = 0; k < 3; k++) model_read(wrap_addr(c, l, 1, k - 1), wt, m[2][k]);
            end
        endcase
    endtask

    function automatic logic [71:0] model_window();
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) for (int k = 0; k < 3; k++) w[(r*3+k)*8 +: 8] = m[r][k];
        return w;
    endfunction

    function automatic logic [23:0] log3();
        if (rd_log.size() < 3) return 24'hxxxxxx;
        return {rd_log[0], rd_log[1], rd_log[2]};
    endfunction

    task automatic run_op(input string tag, input bit is_load, input logic [1:0] dir, input logic [7:0] c,
                          input logic [11:0] len, input int wt, input bit poke);
        int cyc;
        logic [7:0] got;
        wait_cfg = wt;
        model_op(is_load ? 2'b00 : dir, c, len[7:0], wt);
        @(posedge clk); #1;
        load_initial = is_load;
        fetch_req    = !is_load;
        direction    = dir;
        center_addr  = c;
        length       = len;
        @(posedge clk); #1;
        load_initial = 1'b0;
        fetch_req    = 1'b0;
        rd_log.delete();
        check_eq({tag, "_busy"}, 72'(busy), 72'(1'b1));
        check_eq({tag, "_read"}, 72'(mem_read), 72'(1'b1));
        check_eq({tag, "_first"}, 72'(mem_addr), 72'(exp_addr[0]));
        cyc = 0;
        while (!window_valid && cyc < 1000) begin
            fetch_req = poke && (cyc == 4);
            direction = poke ? 2'b10 : dir;
            @(posedge clk); #1;
            cyc++;
        end
        fetch_req = 1'b0;
        direction = dir;
        check_eq({tag, "_latency"}, 72'(cyc), 72'(exp_lat));
        check_eq({tag, "_nreads"}, 72'(rd_log.size()), 72'(exp_log.size()));
        for (int i = 0; i < exp_log.size(); i++) begin
            got = (i < rd_log.size()) ? rd_log[i] : 8'hxx;
            check_eq($sformatf("%s_addr%0d", tag, i), 72'(got), 72'(exp_log[i]));
        end
        check_eq({tag, "_window"}, window, model_window());
        check_eq({tag, "_idle"}, 72'(busy), 72'(1'b0));
        check_eq({tag, "_err"}, 72'(fetch_err), 72'(exp_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_addr"}, 72'(mem_addr), 72'(8'h00));
        check_eq({tag, "_read"}, 72'(mem_read), 72'(1'b0));
        check_eq({tag, "_window"}, window, 72'h0);
        check_eq({tag, "_valid"}, 72'(window_valid), 72'(1'b0));
        check_eq({tag, "_busy"}, 72'(busy), 72'(1'b0));
        check_eq({tag, "_err"}, 72'(fetch_err), 72'(1'b0));
    endtask

    initial begin
        int op;
        n_reset = 1'b0; load_initial = 1'b0; fetch_req = 1'b0;
        direction = 2'b00; center_addr = 8'h00; length = 12'd0;
        for (int a = 0; a < 256; a++) mem[a] = 8'(a);
        for (int r = 0; r < 3; r++) for (int k = 0; k < 3; k++) m[r][k] = 8'h00;
        full_exp = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32};
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        n_reset = 1'b1;

        run_op("full", 1'b1, 2'b00, 8'h21, 12'd16, 0, 1'b0);
        for (int i = 0; i < 9; i++)
            check_eq($sformatf("full_const%0d", i), 72'((i < rd_log.size()) ? rd_log[i] : 8'hxx), 72'(full_exp[i]));
        check_eq("full_window_const", window, 72'h323130222120121110);

        run_op("right", 1'b0, 2'b01, 8'h22, 12'd16, 0, 1'b0);
        check_eq("right_reads", 72'(log3()), 72'(24'h132333));
        check_eq("right_row0", 72'(window[23:0]), 72'(24'h131211));

        run_op("left", 1'b0, 2'b10, 8'h21, 12'd16, 0, 1'b0);
        check_eq("left_reads", 72'(log3()), 72'(24'h102030));

        run_op("down", 1'b0, 2'b11, 8'h31, 12'd16, 0, 1'b0);
        check_eq("down_reads", 72'(log3()), 72'(24'h404142));
        check_eq("down_row0", 72'(window[23:0]), 72'(24'h222120));

        run_op("wait", 1'b0, 2'b01, 8'h32, 12'd16, 3, 1'b1);
        check_eq("wait_lat12", 72'(exp_lat), 72'(12));

        wait_cfg = 3;
        @(posedge clk); #1;
        fetch_req = 1'b1; direction = 2'b10; center_addr = 8'h31; length = 12'd16;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("abort_pre_busy", 72'(busy), 72'(1'b1));
        run_op("abort", 1'b1, 2'b00, 8'h31, 12'd16, 3, 1'b0);
        check_eq("abort_first_const", 72'((rd_log.size() > 0) ? rd_log[0] : 8'hxx), 72'(8'h20));

        @(posedge clk); #1;
        load_initial = 1'b1; center_addr = 8'h55; length = 12'd16;
        @(posedge clk); #1;
        load_initial = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("rstmid_busy", 72'(busy), 72'(1'b1));
        n_reset = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("rstmid");
        n_reset = 1'b1;
        for (int r = 0; r < 3; r++) for (int k = 0; k < 3; k++) m[r][k] = 8'h00;
        exp_err = 1'b0;

        run_op("wrap", 1'b1, 2'b00, 8'h00, 12'd16, 0, 1'b0);
        check_eq("wrap_first_const", 72'((rd_log.size() > 0) ? rd_log[0] : 8'hxx), 72'(8'hEF));

`ifdef FETCH_TIMEOUT_EN
        noack_en = 1'b1;
        noack_addr = 8'hF0;
        exp_err = 1'b1;
        run_op("tmo", 1'b1, 2'b00, 8'h00, 12'd16, 0, 1'b0);
        check_eq("tmo_byte", 72'(window[15:8]), 72'(8'h00));
        noack_en = 1'b0;
`endif

        for (int it = 0; it < 20; it++) begin
            for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
            op = int'($urandom_range(0, 4));
            run_op($sformatf("rnd%0d", it), op == 0, (op == 0) ? 2'b00 : 2'(op - 1),
                   8'($urandom), 12'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        check_eq("addr_stable", 72'(stab_err), 72'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/window_fetch.md
# window_fetch

Fetches image pixels from the 8-bit-addressed frame memory and maintains the live 3x3 Sobel window around the current centre pixel. It is the consumer of the serpentine scan address stream. On a restart it loads all 9 pixels; after each single-pixel move (right, left, or down one row) it reads only the 3 newly exposed pixels and shifts the window. It sits between the scan/move controller and the Sobel gradient datapath.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, cycles to wait for mem_ack before a read is abandoned (used only with the timeout feature).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- n_reset  in  1  reset; synchronous and active-low.
- load_initial  in  1  pulse: start a full 9-pixel load around center_addr.
- fetch_req  in  1  pulse: start an incremental 3-pixel fetch for `direction`.
- direction  in  2  01 right, 10 left, 11 down one row; 00 is treated as a full load.
- center_addr  in  8  address of the new centre pixel; must be stable while busy.
- length  in  12  image row length in pixels; only bits [7:0] are used in address arithmetic.
- mem_addr  out  8  read address.
- mem_read  out  1  read request; held high until the cycle mem_ack is seen.
- mem_rdata  in  8  read data, valid when mem_ack=1.
- mem_ack  in  1  read completion.
- window  out  72  pixel p[i] at bits [8i+7:8i]; i = row*3+col; row 0 is top, col 0 is left.
- window_valid  out  1  window is complete for the current centre.
- busy  out  1  a fetch is in progress.
- fetch_err  out  1  sticky read-timeout flag.

## Operation
- States: IDLE, FULL (9 reads), PART (3 reads), DONE.
- Address arithmetic is modulo 256, with L = length[7:0] and c = center_addr.
- **FULL** read order is row-major, starting at c−L−1 and ending at c+L+1. Each returned byte is written directly to p[0]…p[8].
- **PART, right (01):**
  - Shift columns left: p[r][0]←p[r][1], p[r][1]←p[r][2].
  - Read c−L+1, c+1, c+L+1 into p[0][2], p[1][2], p[2][2].
- **PART, left (10):**
  - Shift columns right.
  - Read c−L−1, c−1, c+L−1 into column 0.
- **PART, down (11):**
  - Shift rows up.
  - Read c+L−1, c+L, c+L+1 into row 2.
- The shift is applied in the cycle the request is accepted. Reads are issued in the order listed.
- Only one read is outstanding at a time. The next address is presented in the cycle after the ack.
- Request acceptance:
  - fetch_req is accepted only in IDLE or DONE; it is ignored while busy.
  - load_initial is accepted in any state. If busy, it aborts the current fetch, discards any pending ack, and restarts FULL.
  - If load_initial and fetch_req are asserted in the same cycle, load_initial wins.
- DONE: window_valid=1, busy=0. The state holds until the next accepted request.
- A new accepted request clears window_valid in the following cycle.
- A synchronous reset mid-fetch returns the block to IDLE and drops mem_read in the same edge.

## Timing
- Reset values: mem_addr=0, mem_read=0, window=0, window_valid=0, busy=0, fetch_err=0, state IDLE.
- Accept at edge T: busy=1 and mem_read=1 with the first address from T+1.
- With zero-wait memory (ack in the same cycle as the read), a PART fetch takes 3 cycles and a FULL fetch takes 9 cycles.
- window_valid rises the cycle after the last ack.
- mem_addr is stable whenever mem_read=1 and mem_ack=0.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A per-read counter runs from the cycle mem_read is raised.
  - If TIMEOUT_CYCLES elapse without mem_ack, the byte is taken as 0x00, fetch_err is set (sticky until reset), and the fetch continues.
- FETCH_TIMEOUT_EN undefined:
  - The block waits indefinitely for mem_ack.
  - fetch_err is tied to 0 and no counter logic is present.

## Structure
- Shared package sobel_pkg contains:
  - direction constants DIR_FULL=00, DIR_RIGHT=01, DIR_LEFT=10, DIR_DOWN=11;
  - the fetch state enum;
  - the window index constants.
- Sub-module window_addr_gen is combinational. Given c, L, direction and read index 0..8, it returns the address and the destination window slot.

## Test plan
- Full load: reset, then load_initial with c=0x21, L=16, zero-wait memory returning data = addr. Expect addresses 0x10,0x11,0x12,0x20,0x21,0x22,0x30,0x31,0x32, window p[i] equal to those values, and window_valid at T+10.
- Right move: after the full load, fetch_req with dir=01, c=0x22. Expect reads 0x13, 0x23, 0x33 and window columns {0x11,0x12,0x13} on row 0.
- Left and down moves, data = addr:
  - dir=10, c=0x21 → reads 0x10, 0x20, 0x30.
  - dir=11, c=0x31 → reads 0x40, 0x41, 0x42; row 0 becomes {0x20,0x21,0x22}.
- Wait-state memory: ack delayed 3 cycles per read. Expect mem_addr stable while pending and a PART fetch completing in 12 cycles. Also apply fetch_req while busy → ignored.
- Abort and reset: load_initial mid-PART → FULL restarts from c−L−1. Separately, n_reset low mid-FULL → all outputs at reset values on the next edge.
- Address wrap and timeout:
  - c=0x00, L=16 → first address 0xEF.
  - With FETCH_TIMEOUT_EN and no ack for 16 cycles → byte reads 0x00, fetch_err=1, and the fetch completes.
